// File: rtl/can_error_frame_ctrl_pkg.sv
// CAN error-frame controller shared types and constants.
// Holds the FSM state enum and the frame/recovery lengths.
package can_err_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLAG     = 3'd1,
    WAIT_REC = 3'd2,
    DELIM    = 3'd3,
    BUSOFF   = 3'd4
  } err_state_t;

  localparam int ERR_FLAG_LEN   = 6;
  localparam int ERR_DELIM_LEN  = 8;
  localparam int BUSOFF_SEQ_LEN = 11;
  localparam int BUSOFF_SEQ_CNT = 128;

endpackage

// File: rtl/can_error_frame_ctrl_busoff_counter.sv
// Bus-off recovery counter: counts runs of 11 recessive samples.
// Ports: clk, rst (async, active-low), i_en (in BUSOFF),
//   i_sample (bit strobe), i_rx (bus level),
//   o_reached (128th run seen, including this sample).
module can_busoff_counter
  import can_err_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_sample,
  input  logic i_rx,
  output logic o_reached
);

  logic [3:0] r_rec11_cnt;
  logic [3:0] w_rec11_nxt;
  logic [7:0] r_occ_cnt;
  logic [7:0] w_occ_nxt;

  always_comb begin
    w_rec11_nxt = r_rec11_cnt;
    w_occ_nxt   = r_occ_cnt;
    if (!i_en) begin
      w_rec11_nxt = 4'd0;
      w_occ_nxt   = 8'd0;
    end else if (i_sample) begin
      if (!i_rx) begin
        w_rec11_nxt = 4'd0;
      end else if (r_rec11_cnt == 4'(BUSOFF_SEQ_LEN - 1)) begin
        w_rec11_nxt = 4'd0;
        if (r_occ_cnt != 8'(BUSOFF_SEQ_CNT))
          w_occ_nxt = r_occ_cnt + 8'd1;
      end else begin
        w_rec11_nxt = r_rec11_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rec11_cnt <= 4'd0;
      r_occ_cnt   <= 8'd0;
    end else begin
      r_rec11_cnt <= w_rec11_nxt;
      r_occ_cnt   <= w_occ_nxt;
    end
  end

  // Look-ahead so the top can leave BUSOFF on the 128th run itself.
  assign o_reached = (w_occ_nxt == 8'(BUSOFF_SEQ_CNT));

endmodule

// File: rtl/can_error_frame_ctrl.sv
// CAN error-frame controller: sends the error flag, waits for
// recessive, counts the delimiter, and handles bus-off.
// Ports: clk, rst (async, active-low); sample_point, rx_bit;
//   bit/stuff/form/crc/ack_error strobes; error_active,
//   error_passive, bus_off; err_tx_en/err_tx_bit (tx override);
//   error_frame_active, dominant_after_flag, busoff_recovered,
//   state_o. Optional: CAN_BUSOFF_RECOVERY_EN enables recovery
//   from BUSOFF after 128 runs of 11 recessive samples.
module can_error_frame_ctrl
  import can_err_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_point,
  input  logic       rx_bit,
  input  logic       bit_error,
  input  logic       stuff_error,
  input  logic       form_error,
  input  logic       crc_error,
  input  logic       ack_error,
  input  logic       error_active,
  input  logic       error_passive,
  input  logic       bus_off,
  output logic       err_tx_en,
  output logic       err_tx_bit,
  output logic       error_frame_active,
  output logic       dominant_after_flag,
  output logic       busoff_recovered,
  output logic [2:0] state_o
);

  err_state_t r_state;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_delim_cnt;
  logic       r_passive;
  logic       r_dom_seen;
  logic       r_tx_en;
  logic       r_tx_bit;
  logic       r_frame_act;
  logic       r_dom_pulse;
  logic       w_any_err;
  logic       w_passive;

  assign w_any_err = bit_error | stuff_error | form_error
                   | crc_error | ack_error;

  // A node flagged neither active nor passive sends the
  // recessive (passive) flag, the non-destructive choice.
  assign w_passive = error_passive | ~error_active;

`ifdef CAN_BUSOFF_RECOVERY_EN
  logic r_recovered;
  logic w_reached;

  can_busoff_counter u_busoff_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_en      (r_state == BUSOFF),
    .i_sample  (sample_point),
    .i_rx      (rx_bit),
    .o_reached (w_reached)
  );

  assign busoff_recovered = r_recovered;
`else
  assign busoff_recovered = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_delim_cnt <= 4'd0;
      r_passive   <= 1'b0;
      r_dom_seen  <= 1'b0;
      r_tx_en     <= 1'b0;
      r_tx_bit    <= 1'b1;
      r_frame_act <= 1'b0;
      r_dom_pulse <= 1'b0;
`ifdef CAN_BUSOFF_RECOVERY_EN
      r_recovered <= 1'b0;
`endif
    end else begin
      r_dom_pulse <= 1'b0;
`ifdef CAN_BUSOFF_RECOVERY_EN
      r_recovered <= 1'b0;
`endif
      if (bus_off) begin
        r_state     <= BUSOFF;
        r_bit_cnt   <= 3'd0;
        r_delim_cnt <= 4'd0;
        r_tx_en     <= 1'b1;
        r_tx_bit    <= 1'b1;
        r_frame_act <= 1'b0;
      end else if (sample_point) begin
        case (r_state)
          IDLE: begin
            if (w_any_err) begin
              r_state     <= FLAG;
              r_bit_cnt   <= 3'd0;
              r_passive   <= w_passive;
              r_dom_seen  <= 1'b0;
              r_tx_en     <= 1'b1;
              r_tx_bit    <= w_passive;
              r_frame_act <= 1'b1;
            end
          end
          FLAG: begin
            if (r_bit_cnt == 3'(ERR_FLAG_LEN - 1)) begin
              r_state  <= WAIT_REC;
              r_tx_bit <= 1'b1;
            end else if (r_bit_cnt != 3'd7) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          WAIT_REC: begin
            if (rx_bit) begin
              r_state     <= DELIM;
              r_delim_cnt <= 4'd1;
            end else if (!r_dom_seen) begin
              r_dom_pulse <= 1'b1;
              r_dom_seen  <= 1'b1;
            end
          end
          DELIM: begin
            if (!rx_bit) begin
              r_state     <= FLAG;
              r_bit_cnt   <= 3'd0;
              r_delim_cnt <= 4'd0;
              r_passive   <= w_passive;
              r_dom_seen  <= 1'b0;
              r_tx_bit    <= w_passive;
            end else if (r_delim_cnt ==
                         4'(ERR_DELIM_LEN - 1)) begin
              r_state     <= IDLE;
              r_delim_cnt <= 4'd0;
              r_tx_en     <= 1'b0;
              r_frame_act <= 1'b0;
            end else if (r_delim_cnt != 4'hF) begin
              r_delim_cnt <= r_delim_cnt + 4'd1;
            end
          end
          BUSOFF: begin
`ifdef CAN_BUSOFF_RECOVERY_EN
            if (w_reached) begin
              r_state     <= IDLE;
              r_tx_en     <= 1'b0;
              r_tx_bit    <= 1'b1;
              r_recovered <= 1'b1;
            end
`endif
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign err_tx_en           = r_tx_en;
  assign err_tx_bit          = r_tx_bit;
  assign error_frame_active  = r_frame_act;
  assign dominant_after_flag = r_dom_pulse;
  assign state_o             = r_state;

endmodule

// File: doc/can_error_frame_ctrl.md
CAN_ERROR_FRAME_CTRL -- requirements
Module: can_error_frame_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have: sample_point  in  1  one-cycle bit-sample strobe; rx_bit  in  1  sampled bus level (1 = recessive).
REQ-003 SHALL have: bit_error, stuff_error, form_error, crc_error, ack_error  in  1 each  error strobes, valid with sample_point.
REQ-004 SHALL have: error_active, error_passive, bus_off  in  1 each  fault-confinement state.
REQ-005 SHALL have: err_tx_en  out  1  overrides transmitter; err_tx_bit  out  1  bit driven while err_tx_en = 1.
REQ-006 SHALL have: error_frame_active  out  1  frame in progress; dominant_after_flag  out  1  one-cycle pulse.
REQ-007 SHALL have: busoff_recovered  out  1  one-cycle pulse; state_o  out  3  current FSM state.

Function
REQ-008 SHALL advance state and counters only on cycles with sample_point = 1, except for the bus_off override in REQ-015.
REQ-009 SHALL have the states IDLE, FLAG, WAIT_REC, DELIM and BUSOFF.
REQ-010 IDLE: any error strobe at sample_point SHALL go to FLAG, clear bit_cnt, and latch passive_flag = error_passive.
REQ-011 FLAG: SHALL drive err_tx_en = 1 and err_tx_bit = passive_flag, i.e. 0 when active, 1 when passive.
REQ-012 FLAG: on the 6th sample_point, bit_cnt 0..5 with bit_cnt = 5, the FSM SHALL go to WAIT_REC.
REQ-013 WAIT_REC:
- SHALL drive err_tx_en = 1 and err_tx_bit = 1.
- The first rx_bit = 0 sample SHALL pulse dominant_after_flag exactly once per frame.
- An rx_bit = 1 sample SHALL go to DELIM with delim_cnt = 1.
REQ-014 DELIM:
- SHALL drive recessive.
- Each recessive sample SHALL increment delim_cnt (4-bit); at delim_cnt = 8 the FSM SHALL go to IDLE.
- A dominant sample SHALL go to FLAG with bit_cnt cleared and passive_flag relatched.
REQ-015 bus_off = 1 SHALL force BUSOFF on the next clk from any state, independent of sample_point. bus_off has priority over simultaneous error strobes.
REQ-016 BUSOFF: SHALL drive err_tx_en = 1 and err_tx_bit = 1. Error strobes SHALL be ignored.
REQ-017 error_frame_active SHALL be 1 in FLAG, WAIT_REC and DELIM.
REQ-018 All outputs SHALL be registered; err_tx_en SHALL rise one clk after the erroring sample_point.
REQ-019 Error strobes in FLAG and WAIT_REC SHALL be ignored; no restart.
REQ-020 Counters SHALL saturate, never wrap.

Reset
REQ-021 rst = 0 SHALL force:
- state IDLE;
- all counters 0 and passive_flag 0;
- err_tx_en = 0, err_tx_bit = 1, error_frame_active = 0, dominant_after_flag = 0, busoff_recovered = 0, state_o = IDLE.
REQ-022 Reset asserted mid-frame SHALL abort immediately with no pulse emitted.

Configuration
REQ-023 Macro CAN_BUSOFF_RECOVERY_EN defined: in BUSOFF the block SHALL count 11 consecutive recessive samples as one occurrence.
- rec11_cnt (4-bit) SHALL clear on a dominant sample.
- occ_cnt (8-bit) SHALL count occurrences.
- The 128th occurrence SHALL pulse busoff_recovered and go to IDLE once bus_off = 0.
REQ-024 Macro undefined: BUSOFF SHALL be exited only by reset, and busoff_recovered SHALL be tied 0.

Structure
REQ-025 Package can_err_pkg SHALL hold:
- the state enum err_state_t (3-bit);
- constants ERR_FLAG_LEN = 6, ERR_DELIM_LEN = 8, BUSOFF_SEQ_LEN = 11 and BUSOFF_SEQ_CNT = 128.
REQ-026 Sub-module can_busoff_counter SHALL implement the recovery counting in REQ-023, instantiated only under CAN_BUSOFF_RECOVERY_EN.

Verification
REQ-027 Bench SHALL cover: error_active = 1, stuff_error at sample 0 -> err_tx_bit = 0 for 6 samples, then 1; state reaches IDLE after the 8th recessive delimiter sample.
REQ-028 Bench SHALL cover: error_passive = 1, crc_error -> err_tx_bit = 1 for 6 samples, then WAIT_REC.
REQ-029 Bench SHALL cover: after the flag, rx_bit = 0 for 3 samples -> exactly one dominant_after_flag pulse; DELIM is entered on the 4th sample with rx_bit = 1.
REQ-030 Bench SHALL cover: DELIM at delim_cnt = 4 with rx_bit = 0 -> state FLAG, bit_cnt = 0.
REQ-031 Bench SHALL cover: bus_off = 1 in FLAG with no sample_point -> BUSOFF next clk. With CAN_BUSOFF_RECOVERY_EN, 128 × 11 recessive samples -> busoff_recovered = 1 for one clk.
REQ-032 Bench SHALL cover: rst = 0 asserted mid-WAIT_REC -> all outputs at REQ-021 values in the same cycle.
